// File: rtl/cfb_pkg.sv
// Shared types and constants for the cache fill buffer: state encoding,
// burst geometry and the word-offset helper.
package cfb_pkg;

   localparam int BURST_LEN = 8;
   localparam int WORD_W    = 16;
   localparam int OFS_W     = 3;
   localparam int CNT_W     = OFS_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      COLLECT,
      REPLAY,
      DONE
   } state_t;

   // Word offset within the line, wrapping modulo the burst length.
   function automatic logic [OFS_W-1:0] ofs_next(input logic [OFS_W-1:0] ofs);
      return ofs + 1'b1;
   endfunction

endpackage

// File: rtl/cfb_line_buf.sv
// 8 x 16 line buffer: one synchronous write port, one asynchronous read port.
// Contents are not reset; every word is rewritten before it is replayed.
module cfb_line_buf
   import cfb_pkg::*;
(
   input  logic              clk,
   input  logic              wen,
   input  logic [OFS_W-1:0]  waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [OFS_W-1:0]  raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [BURST_LEN];

   always_ff @(posedge clk) begin
      if (wen) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_fill_buffer.sv
// Issues one aligned 8-word burst per cache line fill, gathers gapped returns and replays
// them critical-word-first as a gap-free stream. Optional retry on stall: CFB_TIMEOUT_EN.
module cache_fill_buffer
   import cfb_pkg::*;
#(
   parameter int ADDR_W  = 26,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cache_req,
   input  logic [ADDR_W-1:0] cache_addr,
   output logic              cache_fill,
   output logic [WORD_W-1:0] cache_data,
   output logic              mem_req,
   output logic [ADDR_W-5:0] mem_addr,
   input  logic              mem_ack,
   input  logic              mem_valid,
   input  logic [WORD_W-1:0] mem_data,
   output logic [7:0]        retry_cnt
);

   localparam int LINE_W = ADDR_W - 4;

   state_t              state_q, state_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [OFS_W-1:0]    crit_q, crit_d;
   logic [CNT_W-1:0]    wcnt_q, wcnt_d;
   logic [OFS_W-1:0]    rptr_q, rptr_d;
   logic [OFS_W-1:0]    rcnt_q, rcnt_d;
   logic                mem_req_q, mem_req_d;
   logic                fill_q, fill_d;
   logic [WORD_W-1:0]   data_q, data_d;

   logic                accept;
   logic                last_word;
   logic                start_replay;
   logic                tmo_fire;
   logic [OFS_W-1:0]    raddr;
   logic [WORD_W-1:0]   rd_word;
   logic [WORD_W-1:0]   first_word;
   logic                unused_addr_lsb;

   assign unused_addr_lsb = cache_addr[0];

   // Words are taken while the request is outstanding or being collected, up to one line.
   assign accept    = mem_valid && ((state_q == REQ) || (state_q == COLLECT)) && !wcnt_q[OFS_W];
   assign last_word = accept && (wcnt_q == CNT_W'(BURST_LEN - 1));

   // A line completed in REQ without ack waits for the ack before replaying.
   assign start_replay = (last_word && ((state_q == COLLECT) || mem_ack))
                       || ((state_q == COLLECT) && wcnt_q[OFS_W]);

   assign raddr = (state_q == REPLAY) ? rptr_q : crit_q;

   // The final word lands in slot 7 on the same edge it is needed, so bypass it.
   assign first_word = (last_word && (crit_q == OFS_W'(BURST_LEN - 1))) ? mem_data : rd_word;

   cfb_line_buf u_line_buf (
      .clk   (clk),
      .wen   (accept),
      .waddr (wcnt_q[OFS_W-1:0]),
      .wdata (mem_data),
      .raddr (raddr),
      .rdata (rd_word)
   );

`ifdef CFB_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic [7:0]       retry_q, retry_d;

   always_comb begin
      tmo_d    = tmo_q;
      retry_d  = retry_q;
      tmo_fire = 1'b0;
      if (((state_q == REQ) && mem_ack) || accept) begin
         tmo_d = TMO_W'(TIMEOUT);
      end else if (state_q == COLLECT && !wcnt_q[OFS_W]) begin
         if (tmo_q <= TMO_W'(1)) begin
            tmo_fire = 1'b1;
            tmo_d    = TMO_W'(TIMEOUT);
            if (retry_q != 8'hFF) begin
               retry_d = retry_q + 8'd1;
            end
         end else begin
            tmo_d = tmo_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tmo_q   <= TMO_W'(TIMEOUT);
         retry_q <= 8'd0;
      end else begin
         tmo_q   <= tmo_d;
         retry_q <= retry_d;
      end
   end

   assign retry_cnt = retry_q;
`else
   localparam int UNUSED_TIMEOUT = TIMEOUT;

   assign tmo_fire  = 1'b0;
   assign retry_cnt = 8'd0;
`endif

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      crit_d    = crit_q;
      wcnt_d    = wcnt_q;
      rptr_d    = rptr_q;
      rcnt_d    = rcnt_q;
      mem_req_d = mem_req_q;
      fill_d    = 1'b0;
      data_d    = data_q;

      if (accept) begin
         wcnt_d = wcnt_q + 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (cache_req) begin
               line_d    = cache_addr[ADDR_W-1:4];
               crit_d    = cache_addr[3:1];
               wcnt_d    = '0;
               mem_req_d = 1'b1;
               state_d   = REQ;
            end
         end
         REQ: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = COLLECT;
            end
         end
         COLLECT: begin
            if (tmo_fire) begin
               wcnt_d    = '0;
               mem_req_d = 1'b1;
               state_d   = REQ;
            end
         end
         REPLAY: begin
            data_d = rd_word;
            rptr_d = ofs_next(rptr_q);
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == OFS_W'(BURST_LEN - 1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // Wait for the cache to drop its level request before rearming.
            if (!cache_req) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // The critical word goes out on the edge that completes the line.
      if (start_replay) begin
         state_d   = REPLAY;
         mem_req_d = 1'b0;
         fill_d    = 1'b1;
         data_d    = first_word;
         rptr_d    = ofs_next(crit_q);
         rcnt_d    = OFS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         line_q    <= '0;
         crit_q    <= '0;
         wcnt_q    <= '0;
         rptr_q    <= '0;
         rcnt_q    <= '0;
         mem_req_q <= 1'b0;
         fill_q    <= 1'b0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         line_q    <= line_d;
         crit_q    <= crit_d;
         wcnt_q    <= wcnt_d;
         rptr_q    <= rptr_d;
         rcnt_q    <= rcnt_d;
         mem_req_q <= mem_req_d;
         fill_q    <= fill_d;
         data_q    <= data_d;
      end
   end

   assign cache_fill = fill_q;
   assign cache_data = data_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = line_q;

endmodule

// File: tb/tb_cache_fill_buffer.sv
// Bench for cache_fill_buffer: a controller model returns a burst with random gaps and
// the replay is checked against words[(crit + i) % 8].
module tb_cache_fill_buffer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cache_req = 1'b0;
   logic [25:0] cache_addr = '0;
   logic        cache_fill;
   logic [15:0] cache_data;
   logic        mem_req;
   logic [21:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic        mem_valid = 1'b0;
   logic [15:0] mem_data = '0;
   logic [7:0]  retry_cnt;

   int checks = 0;
   int errors = 0;

   logic [15:0] words [8];
   logic [15:0] obs_data [8];
   logic        obs_fill [8];
   logic        req_seen, req_hold_ok, req_after_ack, early_fill, post_fill, replay_req;

   cache_fill_buffer #(.ADDR_W(26), .TIMEOUT(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cache_req  (cache_req),
      .cache_addr (cache_addr),
      .cache_fill (cache_fill),
      .cache_data (cache_data),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ack    (mem_ack),
      .mem_valid  (mem_valid),
      .mem_data   (mem_data),
      .retry_cnt  (retry_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_word(input logic [25:0] addr, input int r);
      int c;
      c = int'(addr[3:1]);
      return words[(c + r) % 8];
   endfunction

   function automatic logic [21:0] exp_line(input logic [25:0] addr);
      return addr[25:4];
   endfunction

   task automatic rand_words();
      for (int i = 0; i < 8; i++) words[i] = 16'($urandom_range(1, 16'hFFFF));
   endtask

   task automatic issue_req(input logic [25:0] addr);
      cache_addr = addr;
      cache_req  = 1'b1;
      tick();
      req_seen = mem_req;
   endtask

   task automatic do_ack(input int lat, input logic [21:0] line);
      req_hold_ok = 1'b1;
      for (int i = 0; i < lat; i++) begin
         if (mem_req !== 1'b1 || mem_addr !== line) req_hold_ok = 1'b0;
         tick();
      end
      if (mem_req !== 1'b1 || mem_addr !== line) req_hold_ok = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      req_after_ack = mem_req;
   endtask

   task automatic send_words(input int lo, input int hi, input int max_gap);
      early_fill = 1'b0;
      for (int i = lo; i <= hi; i++) begin
         mem_valid = 1'b0;
         repeat ($urandom_range(0, max_gap)) begin
            if (cache_fill !== 1'b0) early_fill = 1'b1;
            tick();
         end
         if (cache_fill !== 1'b0) early_fill = 1'b1;
         mem_valid = 1'b1;
         mem_data  = words[i];
         tick();
      end
      mem_valid = 1'b0;
   endtask

   task automatic capture_replay(input bit stray);
      replay_req = 1'b0;
      mem_valid  = stray;
      mem_data   = 16'($urandom);
      for (int r = 0; r < 8; r++) begin
         obs_fill[r] = cache_fill;
         obs_data[r] = cache_data;
         if (mem_req !== 1'b0) replay_req = 1'b1;
         tick();
         mem_valid = 1'b0;
      end
      post_fill = cache_fill;
   endtask

   task automatic release_req();
      cache_req = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      checks++;
      if ({cache_fill, cache_data, mem_req, mem_addr, retry_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_values got fill=%b data=%h req=%b addr=%h retry=%0d want all 0",
                  cache_fill, cache_data, mem_req, mem_addr, retry_cnt);
      end
   endtask

   task automatic test_gap_free();
      logic [25:0] addr = 26'h000124;
      for (int i = 0; i < 8; i++) words[i] = 16'hA0 + 16'(i);
      issue_req(addr);
      checks++;
      if (req_seen !== 1'b1 || mem_addr !== 22'h00012) begin
         errors++;
         $display("FAIL gapfree_req got req=%b addr=%h want req=1 addr=00012", req_seen, mem_addr);
      end
      do_ack(int'($urandom_range(0, 3)), 22'h00012);
      checks++;
      if (req_hold_ok !== 1'b1 || req_after_ack !== 1'b0) begin
         errors++;
         $display("FAIL gapfree_ack got hold=%b after_ack=%b want hold=1 after_ack=0", req_hold_ok, req_after_ack);
      end
      send_words(0, 7, 0);
      capture_replay(1'b0);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== 16'hA0 + 16'((r + 2) % 8) || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL gapfree_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], 16'hA0 + 16'((r + 2) % 8), r == 0);
         end
      end
      checks++;
      if (early_fill !== 1'b0 || post_fill !== 1'b0 || replay_req !== 1'b0) begin
         errors++;
         $display("FAIL gapfree_strobe got early=%b post=%b req=%b want 0 0 0", early_fill, post_fill, replay_req);
      end
      release_req();
   endtask

   task automatic test_gapped();
      for (int it = 0; it < 4; it++) begin
         logic [25:0] addr;
         addr = (it == 0) ? 26'h000124 : 26'($urandom);
         rand_words();
         issue_req(addr);
         cache_addr = 26'($urandom);
         do_ack(int'($urandom_range(0, 4)), exp_line(addr));
         checks++;
         if (req_seen !== 1'b1 || req_hold_ok !== 1'b1 || req_after_ack !== 1'b0) begin
            errors++;
            $display("FAIL gapped_req[%0d] got seen=%b hold=%b after_ack=%b want 1 1 0",
                     it, req_seen, req_hold_ok, req_after_ack);
         end
         send_words(0, 7, 5);
         capture_replay(1'b0);
         for (int r = 0; r < 8; r++) begin
            checks++;
            if (obs_data[r] !== exp_word(addr, r) || obs_fill[r] !== (r == 0)) begin
               errors++;
               $display("FAIL gapped_replay[%0d][%0d] got data=%h fill=%b want data=%h fill=%b",
                        it, r, obs_data[r], obs_fill[r], exp_word(addr, r), r == 0);
            end
         end
         checks++;
         if (early_fill !== 1'b0 || post_fill !== 1'b0) begin
            errors++;
            $display("FAIL gapped_strobe[%0d] got early=%b post=%b want 0 0", it, early_fill, post_fill);
         end
         release_req();
      end
   endtask

   task automatic test_sticky();
      logic [25:0] addr = 26'h1234566;
      logic        rereq = 1'b0;
      rand_words();
      issue_req(addr);
      do_ack(1, exp_line(addr));
      send_words(0, 7, 2);
      capture_replay(1'b0);
      for (int i = 0; i < 20; i++) begin
         if (mem_req !== 1'b0) rereq = 1'b1;
         tick();
      end
      checks++;
      if (rereq !== 1'b0) begin
         errors++;
         $display("FAIL sticky_no_retrigger got mem_req=1 while request held want 0");
      end
      release_req();
      addr = 26'h0FEDCBA;
      rand_words();
      issue_req(addr);
      checks++;
      if (req_seen !== 1'b1 || mem_addr !== exp_line(addr)) begin
         errors++;
         $display("FAIL sticky_new_req got req=%b addr=%h want req=1 addr=%h", req_seen, mem_addr, exp_line(addr));
      end
      do_ack(0, exp_line(addr));
      send_words(0, 7, 1);
      capture_replay(1'b0);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== exp_word(addr, r) || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL sticky_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], exp_word(addr, r), r == 0);
         end
      end
      release_req();
   endtask

   task automatic test_spurious();
      logic [25:0] addr = 26'h02A5A5A;
      logic        idle_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_valid = 1'b1;
         mem_data  = 16'($urandom);
         tick();
         if (mem_req !== 1'b0 || cache_fill !== 1'b0) idle_req = 1'b1;
      end
      mem_valid = 1'b0;
      checks++;
      if (idle_req !== 1'b0) begin
         errors++;
         $display("FAIL spurious_idle got activity on idle mem_valid want none");
      end
      rand_words();
      issue_req(addr);
      do_ack(2, exp_line(addr));
      send_words(0, 7, 3);
      capture_replay(1'b1);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== exp_word(addr, r) || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL spurious_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], exp_word(addr, r), r == 0);
         end
      end
      release_req();
   endtask

   task automatic test_reset_mid();
      logic [25:0] addr = 26'h0123458;
      rand_words();
      issue_req(addr);
      do_ack(1, exp_line(addr));
      send_words(0, 3, 2);
      reset_n   = 1'b0;
      cache_req = 1'b0;
      tick();
      checks++;
      if ({cache_fill, cache_data, mem_req, mem_addr, retry_cnt} !== '0) begin
         errors++;
         $display("FAIL reset_mid_values got fill=%b data=%h req=%b addr=%h retry=%0d want all 0",
                  cache_fill, cache_data, mem_req, mem_addr, retry_cnt);
      end
      reset_n = 1'b1;
      tick();
      addr = 26'h0ABCDE;
      rand_words();
      issue_req(addr);
      do_ack(0, exp_line(addr));
      send_words(0, 7, 4);
      capture_replay(1'b0);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== words[(7 + r) % 8] || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL reset_crit7_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], words[(7 + r) % 8], r == 0);
         end
      end
      release_req();
   endtask

`ifdef CFB_TIMEOUT_EN
   task automatic test_timeout();
      logic [25:0] addr = 26'h0777770;
      int          idle = 0;
      rand_words();
      issue_req(addr);
      do_ack(1, exp_line(addr));
      send_words(0, 2, 1);
      while (mem_req !== 1'b1 && idle < 100) begin
         tick();
         idle++;
      end
      checks++;
      if (idle !== 16 || mem_addr !== exp_line(addr) || retry_cnt !== 8'd1) begin
         errors++;
         $display("FAIL timeout_retry got idle=%0d addr=%h retry=%0d want idle=16 addr=%h retry=1",
                  idle, mem_addr, retry_cnt, exp_line(addr));
      end
      do_ack(2, exp_line(addr));
      send_words(0, 7, 3);
      capture_replay(1'b0);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== exp_word(addr, r) || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL timeout_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], exp_word(addr, r), r == 0);
         end
      end
      release_req();
   endtask
`else
   task automatic test_timeout();
      logic [25:0] addr = 26'h0777770;
      logic        stray = 1'b0;
      rand_words();
      issue_req(addr);
      do_ack(1, exp_line(addr));
      send_words(0, 2, 1);
      for (int i = 0; i < 40; i++) begin
         if (mem_req !== 1'b0 || retry_cnt !== 8'd0 || cache_fill !== 1'b0) stray = 1'b1;
         tick();
      end
      checks++;
      if (stray !== 1'b0) begin
         errors++;
         $display("FAIL stall_wait got req=%b retry=%0d fill=%b during stall want 0 0 0",
                  mem_req, retry_cnt, cache_fill);
      end
      send_words(3, 7, 2);
      capture_replay(1'b0);
      for (int r = 0; r < 8; r++) begin
         checks++;
         if (obs_data[r] !== exp_word(addr, r) || obs_fill[r] !== (r == 0)) begin
            errors++;
            $display("FAIL stall_replay[%0d] got data=%h fill=%b want data=%h fill=%b",
                     r, obs_data[r], obs_fill[r], exp_word(addr, r), r == 0);
         end
      end
      release_req();
   endtask
`endif

   initial begin
      test_reset();
      test_gap_free();
      test_gapped();
      test_sticky();
      test_spurious();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
